// File: rtl/stencil_draw_scheduler.sv
// Round-robin scheduler sharing one Stencil blitter between N_REQ sprite requesters.
// Launches a blit only in the draw window, waits for it to finish, then acks the winner.
module stencil_draw_scheduler #(
    parameter int N_REQ         = 4,
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int ID_WIDTH      = 4,
    parameter int START_TIMEOUT = 16,
    parameter int CNT_WIDTH     = 5,
    localparam int GW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*X_WIDTH-1:0]    req_x,
    input  logic [N_REQ*Y_WIDTH-1:0]    req_y,
    input  logic [N_REQ*ID_WIDTH-1:0]   req_id,
    output logic [N_REQ-1:0]            ack,
    output logic                        ack_err,
    input  logic                        draw_window,
    output logic                        blit_start,
    output logic [X_WIDTH-1:0]          blit_x,
    output logic [Y_WIDTH-1:0]          blit_y,
    output logic [ID_WIDTH-1:0]         blit_id,
    input  logic                        blit_finish,
    output logic                        busy,
    output logic [GW-1:0]               grant_idx,
    output logic                        err_timeout,
    input  logic                        err_clear
);

    typedef enum logic [2:0] {
        IDLE, ARB, LAUNCH, WAIT_BUSY, WAIT_DONE, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          rr_q, rr_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [X_WIDTH-1:0]     x_q, x_d;
    logic [Y_WIDTH-1:0]     y_q, y_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   abort_q, abort_d;
    logic                   err_q, err_d;

    logic                   win_found;
    logic [GW-1:0]          win_idx;
    logic [GW-1:0]          rr_nxt;
    logic [GW:0]            sum;
    logic [GW-1:0]          cand;

    // Scan starting at rr_q, wrapping modulo N_REQ (N_REQ need not be a power of two).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_q} + (GW+1)'(k);
            if (sum >= (GW+1)'(N_REQ)) begin
                sum = sum - (GW+1)'(N_REQ);
            end
            cand = sum[GW-1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        sum = {1'b0, win_idx} + (GW+1)'(1);
        if (sum == (GW+1)'(N_REQ)) begin
            sum = '0;
        end
        rr_nxt = sum[GW-1:0];
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        x_d     = x_q;
        y_d     = y_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        err_d   = err_q;
        if (err_clear) begin
            err_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (draw_window && (|req) && blit_finish) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (win_found) begin
                    grant_d = win_idx;
                    x_d     = req_x[win_idx*X_WIDTH +: X_WIDTH];
                    y_d     = req_y[win_idx*Y_WIDTH +: Y_WIDTH];
                    id_d    = req_id[win_idx*ID_WIDTH +: ID_WIDTH];
                    rr_d    = rr_nxt;
                    state_d = LAUNCH;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!blit_finish) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_WIDTH'(START_TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (blit_finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A timeout in this cycle beats a simultaneous clear.
                if (abort_q) begin
                    err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            x_q     <= x_d;
            y_q     <= y_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == DONE) begin
            ack[grant_q] = 1'b1;
        end
    end

    assign ack_err     = (state_q == DONE) && abort_q;
    assign blit_start  = (state_q == LAUNCH);
    assign busy        = (state_q != IDLE);
    assign blit_x      = x_q;
    assign blit_y      = y_q;
    assign blit_id     = id_q;
    assign grant_idx   = grant_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_stencil_draw_scheduler.sv
// Bench for stencil_draw_scheduler: a cycle-timeline model of the scheduling rules
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_stencil_draw_scheduler;
    localparam int N  = 4;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int IW = 4;
    localparam int TO = 16;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N*XW-1:0] req_x;
    logic [N*YW-1:0] req_y;
    logic [N*IW-1:0] req_id;
    logic [N-1:0]    ack;
    logic            ack_err;
    logic            draw_window;
    logic            blit_start;
    logic [XW-1:0]   blit_x;
    logic [YW-1:0]   blit_y;
    logic [IW-1:0]   blit_id;
    logic            blit_finish;
    logic            busy;
    logic [1:0]      grant_idx;
    logic            err_timeout;
    logic            err_clear;

    int checks = 0;
    int errors = 0;

    stencil_draw_scheduler #(
        .N_REQ(N), .X_WIDTH(XW), .Y_WIDTH(YW), .ID_WIDTH(IW),
        .START_TIMEOUT(TO), .CNT_WIDTH(5)
    ) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_x(req_x), .req_y(req_y),
        .req_id(req_id), .ack(ack), .ack_err(ack_err), .draw_window(draw_window),
        .blit_start(blit_start), .blit_x(blit_x), .blit_y(blit_y), .blit_id(blit_id),
        .blit_finish(blit_finish), .busy(busy), .grant_idx(grant_idx),
        .err_timeout(err_timeout), .err_clear(err_clear)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Blitter stand-in: on a start pulse, holds finish low for bl_len cycles (or never drops if hung).
    int bl_len  = 20;
    bit bl_hang = 1'b0;
    initial begin
        int  left;
        bit  st;
        left = 0;
        blit_finish = 1'b1;
        forever begin
            @(negedge clock);
            st = blit_start;
            @(posedge clock); #1;
            if (st && !bl_hang) left = bl_len;
            if (left > 0) begin
                blit_finish = 1'b0;
                left--;
            end else begin
                blit_finish = 1'b1;
            end
        end
    end

    // Timeline model: tracks the cycle numbers at which the ARB decision, start pulse and ack must occur.
    int            cyc = 0;
    bit            inflight, dropped, m_abort, m_err;
    int            t_arb, t_start, t_ack, m_rr, m_win;
    logic [XW-1:0] m_x;
    logic [YW-1:0] m_y;
    logic [IW-1:0] m_id;

    always @(negedge clock) begin
        logic [N-1:0] ea;
        int w;
        cyc++;
        if (!reset_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_start", blit_start, 0);
            chk("rst_ack", ack, 0);
            chk("rst_ack_err", ack_err, 0);
            chk("rst_x", blit_x, 0);
            chk("rst_y", blit_y, 0);
            chk("rst_id", blit_id, 0);
            chk("rst_grant", grant_idx, 0);
            chk("rst_err", err_timeout, 0);
            inflight = 0; dropped = 0; m_abort = 0; m_err = 0;
            t_arb = -1; t_start = -1; t_ack = -1; m_rr = 0; m_win = 0;
            m_x = '0; m_y = '0; m_id = '0;
        end else begin
            ea = '0;
            if (cyc == t_ack) ea[m_win] = 1'b1;
            chk("m_busy", busy, inflight);
            chk("m_start", blit_start, cyc == t_start);
            chk("m_ack", ack, ea);
            chk("m_ack_err", ack_err, (cyc == t_ack) && m_abort);
            chk("m_x", blit_x, m_x);
            chk("m_y", blit_y, m_y);
            chk("m_id", blit_id, m_id);
            chk("m_grant", grant_idx, m_win);
            chk("m_err", err_timeout, m_err);

            if (err_clear) m_err = 0;
            if (cyc == t_ack && m_abort) m_err = 1;
            if (!inflight) begin
                if (draw_window && (|req) && blit_finish) begin
                    inflight = 1; t_arb = cyc + 1; t_start = -1; t_ack = -1;
                    dropped = 0; m_abort = 0;
                end
            end else if (cyc == t_arb) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
                end
                if (w < 0) begin
                    inflight = 0;
                end else begin
                    m_win = w;
                    m_x = req_x[w*XW +: XW];
                    m_y = req_y[w*YW +: YW];
                    m_id = req_id[w*IW +: IW];
                    m_rr = (w + 1) % N;
                    t_start = cyc + 1;
                end
            end else if (cyc == t_ack) begin
                inflight = 0;
            end else if (t_ack < 0 && t_start >= 0 && cyc > t_start) begin
                if (!dropped) begin
                    if (!blit_finish) dropped = 1;
                    else if (cyc - t_start == TO) begin
                        m_abort = 1;
                        t_ack = cyc + 1;
                    end
                end else if (blit_finish) begin
                    t_ack = cyc + 1;
                end
            end
        end
    end

    task automatic set_op(input int i, input int x, input int y, input int id);
        req_x[i*XW +: XW] = XW'(x);
        req_y[i*YW +: YW] = YW'(y);
        req_id[i*IW +: IW] = IW'(id);
    endtask

    task automatic wait_ack(output logic [N-1:0] a);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (ack == '0 && n < 200);
        if (ack == '0) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: no ack within %0d cycles", n);
        end
        a = ack;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!blit_start && n < 200);
        if (!blit_start) begin
            checks++;
            errors++;
            $display("FAIL start_wait: no blit_start within %0d cycles", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] a;
        int order [5];
        int cnt, n;
        order = '{0, 1, 2, 3, 0};
        reset_n = 1'b0; req = '0; req_x = '0; req_y = '0; req_id = '0;
        draw_window = 1'b1; err_clear = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_busy", busy, 0);
        chk("reset_ack", ack, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // 1: single request, 2-cycle launch latency, 20-cycle blit
        @(posedge clock); #1;
        set_op(0, 100, 50, 3);
        req[0] = 1'b1;
        @(negedge clock); chk("t1_start_c0", blit_start, 0);
        @(negedge clock); chk("t1_start_c1", blit_start, 0);
        @(negedge clock); chk("t1_start_c2", blit_start, 1);
        @(negedge clock);
        chk("t1_x", blit_x, 100);
        chk("t1_y", blit_y, 50);
        chk("t1_id", blit_id, 3);
        repeat (20) @(negedge clock);
        chk("t1_ack_early", ack, 0);
        @(negedge clock);
        chk("t1_ack", ack, 4'b0001);
        chk("t1_ack_err", ack_err, 0);
        @(posedge clock); #1;
        req = '0;

        // 2: all four requesting, round-robin order from a fresh pointer
        @(posedge clock); #1; reset_n = 1'b0;
        @(posedge clock); #1; reset_n = 1'b1;
        bl_len = 4;
        for (int i = 0; i < N; i++) set_op(i, 10 + i, 20 + i, 5 + i);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(a);
            chk($sformatf("t2_order%0d", k), a, 32'(1) << order[k]);
            @(posedge clock); #1;
            req[order[k]] = 1'b0;
            if (k < 4) begin
                @(posedge clock); #1;
                req[order[k]] = 1'b1;
            end
        end
        req = '0;

        // 3: request held while the draw window is closed
        @(posedge clock); #1;
        draw_window = 1'b0;
        set_op(2, 300, 200, 9);
        req[2] = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(negedge clock);
            if (blit_start) cnt++;
        end
        chk("t3_no_start", cnt, 0);
        @(posedge clock); #1;
        draw_window = 1'b1;
        @(negedge clock); chk("t3_start_w0", blit_start, 0);
        @(negedge clock); chk("t3_start_w1", blit_start, 0);
        @(negedge clock); chk("t3_start_w2", blit_start, 1);
        wait_ack(a);
        chk("t3_ack", a, 4'b0100);
        @(posedge clock); #1;
        req = '0;

        // 4: blitter never goes busy -> timeout, sticky error, clear, and set-beats-clear
        bl_hang = 1'b1;
        @(posedge clock); #1;
        set_op(3, 511, 7, 15);
        req[3] = 1'b1;
        wait_start();
        repeat (16) @(negedge clock);
        chk("t4_ack_early", ack, 0);
        @(negedge clock);
        chk("t4_ack", ack, 4'b1000);
        chk("t4_ack_err", ack_err, 1);
        @(posedge clock); #1;
        req = '0;
        @(negedge clock); chk("t4_err_set", err_timeout, 1);
        repeat (5) @(negedge clock);
        chk("t4_err_sticky", err_timeout, 1);
        @(posedge clock); #1; err_clear = 1'b1;
        @(negedge clock); chk("t4_err_before_clr", err_timeout, 1);
        @(posedge clock); #1; err_clear = 1'b0;
        @(negedge clock); chk("t4_err_cleared", err_timeout, 0);
        @(posedge clock); #1;
        req[3] = 1'b1;
        wait_start();
        repeat (17) @(posedge clock);
        #1; err_clear = 1'b1;
        @(negedge clock); chk("t4_ack2", ack, 4'b1000);
        @(posedge clock); #1; err_clear = 1'b0; req = '0;
        @(negedge clock); chk("t4_set_wins", err_timeout, 1);
        @(posedge clock); #1; err_clear = 1'b1;
        @(posedge clock); #1; err_clear = 1'b0;
        bl_hang = 1'b0;

        // 5: reset during WAIT_DONE while the blitter is still drawing
        bl_len = 40;
        @(posedge clock); #1;
        set_op(1, 42, 24, 6);
        req[1] = 1'b1;
        wait_start();
        repeat (10) @(posedge clock);
        #1;
        bl_len = 5;
        reset_n = 1'b0;
        @(negedge clock);
        chk("t5_busy_rst", busy, 0);
        chk("t5_x_rst", blit_x, 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        n = 11;
        do begin
            @(negedge clock);
            n++;
        end while (!blit_start && n < 80);
        chk("t5_relaunch_cycle", n, 43);
        wait_ack(a);
        chk("t5_ack", a, 4'b0010);
        @(posedge clock); #1;
        req = '0;

        // 6: request withdrawn during ARB; pointer must stay at 2
        @(posedge clock); #1;
        req[1] = 1'b1;
        @(negedge clock); chk("t6_busy_idle", busy, 0);
        @(posedge clock); #1;
        req = '0;
        @(negedge clock); chk("t6_busy_arb", busy, 1);
        @(negedge clock); chk("t6_busy_back", busy, 0);
        cnt = 0;
        repeat (8) begin
            @(negedge clock);
            if (blit_start || (ack != '0)) cnt++;
        end
        chk("t6_quiet", cnt, 0);
        @(posedge clock); #1;
        req = 4'b1010;
        wait_ack(a);
        chk("t6_rr_kept", a, 4'b1000);
        @(posedge clock); #1;
        req[3] = 1'b0;
        wait_ack(a);
        chk("t6_next", a, 4'b0010);
        @(posedge clock); #1;
        req = '0;
        repeat (4) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
